cordic_out_serializer: RTL

CORDIC_OUT_SERIALIZER -- requirements
Module: cordic_out_serializer

---
 rtl/cordic_pkg.sv | 35 +++
 rtl/cordic_ser_fifo.sv | 60 ++++++
 rtl/cordic_out_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC output serializer.
// Packet length depends on the optional header word, enabled by CORDIC_SER_HDR_EN.
package cordic_pkg;

    localparam int unsigned CORDIC_XY_W    = 16;
    localparam int unsigned CORDIC_ANGLE_W = 32;

`ifdef CORDIC_SER_HDR_EN
    localparam int unsigned CORDIC_HDR_WORDS = 1;
`else
    localparam int unsigned CORDIC_HDR_WORDS = 0;
`endif

    // Theta words per packet and total words per packet for the default widths.
    localparam int unsigned CORDIC_NTW     = CORDIC_ANGLE_W / CORDIC_XY_W;
    localparam int unsigned CORDIC_PKT_LEN = CORDIC_HDR_WORDS + 3 + CORDIC_NTW;

    typedef struct packed {
        logic signed [CORDIC_XY_W-1:0]    cos;
        logic signed [CORDIC_XY_W-1:0]    sin;
        logic signed [CORDIC_XY_W-1:0]    mag;
        logic signed [CORDIC_ANGLE_W-1:0] theta;
    } cordic_res_t;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } ser_state_e;

    // Words per packet for an arbitrary theta word count.
    function automatic int unsigned cordic_pkt_len(input int unsigned ntw);
        return CORDIC_HDR_WORDS + 3 + ntw;
    endfunction

endpackage

// File: rtl/cordic_ser_fifo.sv
// Small synchronous FIFO holding CORDIC result beats ahead of the serializer.
// Pointers wrap modulo DEPTH; pushes when full and pops when empty are ignored.
module cordic_ser_fifo
    import cordic_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter type         elem_t = cordic_res_t,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  elem_t            i_wdata,
    input  logic             i_pop,
    output elem_t            o_rdata,
    output logic [CNT_W-1:0] o_count
);

    elem_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_out_serializer.sv
// Serializes CORDIC result beats into a stream of XY_W-bit words:
// [header] cos, sin, mag, theta (MS slice first); s_last marks the final word.
// Optional feature: define CORDIC_SER_HDR_EN to prefix each packet with a
// wrapping sequence-counter header word.
// A beat arriving while the FIFO is empty and a packet may start is loaded
// straight into the output stage, so the first word appears the cycle after
// acceptance and back-to-back packets have no bubble.
module cordic_out_serializer
    import cordic_pkg::*;
#(
    parameter int unsigned XY_W    = 16,
    parameter int unsigned ANGLE_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic signed [XY_W-1:0]    cos_in,
    input  logic signed [XY_W-1:0]    sin_in,
    input  logic signed [XY_W-1:0]    mag_in,
    input  logic signed [ANGLE_W-1:0] theta_in,
    output logic                      s_valid,
    input  logic                      s_ready,
    output logic [XY_W-1:0]           s_data,
    output logic                      s_last
);

    localparam int unsigned NTW        = ANGLE_W / XY_W;
    localparam int unsigned PKT_LEN    = cordic_pkt_len(NTW);
    localparam int unsigned IDX_W      = $clog2(PKT_LEN + 1);
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    if ((ANGLE_W % XY_W) != 0 || ANGLE_W < XY_W) begin : g_bad_width
        $error("ANGLE_W must be a non-zero integer multiple of XY_W");
    end

    typedef struct packed {
        logic signed [XY_W-1:0]    cos;
        logic signed [XY_W-1:0]    sin;
        logic signed [XY_W-1:0]    mag;
        logic signed [ANGLE_W-1:0] theta;
    } res_t;

    // Word idx of a packet built from beat b; idx 0 is the header when enabled.
    function automatic logic [XY_W-1:0] word_at(input res_t b, input logic [IDX_W-1:0] idx,
                                                input logic [XY_W-1:0] seq);
        int unsigned k;
        logic [XY_W-1:0] w;
        w = '0;
        k = int'(idx);
        if (CORDIC_HDR_WORDS != 0 && k == 0) begin
            w = seq;
        end else begin
            k = k - CORDIC_HDR_WORDS;
            if (k == 0) begin
                w = b.cos;
            end else if (k == 1) begin
                w = b.sin;
            end else if (k == 2) begin
                w = b.mag;
            end else if (k < 3 + NTW) begin
                w = b.theta[ANGLE_W - 1 - (k - 3) * XY_W -: XY_W];
            end
        end
        return w;
    endfunction

    ser_state_e       r_state;
    res_t             r_beat;
    logic [IDX_W-1:0] r_idx;
    logic             r_s_valid;
    logic             r_s_last;
    logic [XY_W-1:0]  r_s_data;

    res_t             w_in_beat;
    res_t             w_head;
    res_t             w_src;
    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_fifo_push;
    logic             w_pop;
    logic             w_word_hs;
    logic             w_last_hs;
    logic             w_avail;
    logic             w_start;
    logic [XY_W-1:0]  w_seq;

    assign w_in_beat    = '{cos: cos_in, sin: sin_in, mag: mag_in, theta: theta_in};
    assign w_fifo_empty = (w_fifo_count == '0);
    assign res_ready    = (w_fifo_count < CNT_W'(FIFO_DEPTH));
    assign w_push       = res_valid && res_ready;
    assign w_word_hs    = r_s_valid && s_ready;
    assign w_last_hs    = w_word_hs && r_s_last;

    // A beat is available from the FIFO head or, when empty, straight from the input.
    assign w_avail     = !w_fifo_empty || w_push;
    assign w_src       = w_fifo_empty ? w_in_beat : w_head;
    assign w_start     = w_avail && ((r_state == StIdle) || w_last_hs);
    assign w_pop       = w_start && !w_fifo_empty;
    assign w_fifo_push = w_push && !(w_start && w_fifo_empty);

    assign s_valid = r_s_valid;
    assign s_data  = r_s_data;
    assign s_last  = r_s_last;

    cordic_ser_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .elem_t (res_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fifo_push),
        .i_wdata (w_in_beat),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_fifo_count)
    );

`ifdef CORDIC_SER_HDR_EN
    logic [XY_W-1:0] r_seq;

    // Header for a packet starting on the same edge the previous one completes.
    assign w_seq = w_last_hs ? r_seq + 1'b1 : r_seq;

    // Per-packet sequence counter, advanced on each completed packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq <= '0;
        end else if (w_last_hs) begin
            r_seq <= r_seq + 1'b1;
        end
    end
`else
    assign w_seq = '0;
`endif

    // IDLE/SEND control with registered output word, valid and last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_beat    <= '0;
            r_idx     <= '0;
            r_s_valid <= 1'b0;
            r_s_last  <= 1'b0;
            r_s_data  <= '0;
        end else if (w_start) begin
            r_state   <= StSend;
            r_beat    <= w_src;
            r_s_valid <= 1'b1;
            r_s_data  <= word_at(w_src, '0, w_seq);
            r_s_last  <= 1'b0;
            r_idx     <= IDX_W'(1);
        end else if (w_word_hs) begin
            if (r_s_last) begin
                r_state   <= StIdle;
                r_s_valid <= 1'b0;
                r_s_last  <= 1'b0;
                r_idx     <= '0;
            end else begin
                r_s_data <= word_at(r_beat, r_idx, w_seq);
                r_s_last <= (r_idx == LAST_IDX);
                r_idx    <= r_idx + 1'b1;
            end
        end
    end

endmodule
